// File: rtl/char_motion_ctrl_if.sv
// Command/position bundle between game logic, the motion controller and the sprite stage.
interface char_motion_ctrl_if #(
  parameter int X_W = 10,
  parameter int Y_W = 10
);
  logic           module_en;
  logic           jump_left;
  logic           jump_right;
  logic           jump_fail;
  logic [1:0]     jump_dist;
  logic [X_W-1:0] xpos;
  logic [Y_W-1:0] ypos;
  logic           mirror;
  logic           airborne;
  logic           landed;
  logic           buf_full;

  // game logic side: issues commands, watches position and landing
  modport master (
    output module_en, jump_left, jump_right, jump_fail, jump_dist,
    input  xpos, ypos, mirror, airborne, landed, buf_full
  );

  // controller side
  modport slave (
    input  module_en, jump_left, jump_right, jump_fail, jump_dist,
    output xpos, ypos, mirror, airborne, landed, buf_full
  );
endinterface

// File: rtl/char_motion_ctrl.sv
// Player character motion controller: jump/fall trajectories on a slow movement
// tick, screen-edge clamping, and a one-entry command buffer for chained jumps.
module char_motion_ctrl #(
  parameter int X_W         = 10,
  parameter int Y_W         = 10,
  parameter int START_X     = 355,
  parameter int START_Y     = 454,
  parameter int TICK_DIV    = 78000,
  parameter int JUMP_STEPS  = 80,
  parameter int STEP_X      = 1,
  parameter int STEP_Y      = 2,
  parameter int FALL_STEPS  = 201,
  parameter int FALL_STEP_Y = 1,
  parameter int X_MIN       = 0,
  parameter int X_MAX       = 711,
  parameter int BUF_EN      = 1
) (
  input logic             clk,
  input logic             rst_n,
  char_motion_ctrl_if.slave bus
);

  localparam int TC_W  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int T_MAX = (JUMP_STEPS > FALL_STEPS) ? JUMP_STEPS : FALL_STEPS;
  localparam int T_W   = $clog2(T_MAX + 1);
  localparam int HALF  = JUMP_STEPS / 2;
  // two bits of headroom so x +/- STEP_X*3 and y +/- step never wrap before clamping
  localparam int XS_W  = X_W + 2;
  localparam int YS_W  = Y_W + 2;

  typedef enum logic [1:0] {S_IDLE, S_JUMP, S_FALL} state_t;
  typedef enum logic [1:0] {CMD_LEFT, CMD_RIGHT, CMD_FAIL} cmd_t;

  state_t r_state, w_nxt_state;
  cmd_t   r_bcmd, w_nxt_bcmd, w_cmd, w_lcmd;

  logic [TC_W-1:0] r_tick_cnt;
  logic            w_tick, w_clr;
  logic [T_W-1:0]  r_timer, w_nxt_timer;
  logic            r_dir, w_nxt_dir;
  logic            r_mirror, w_nxt_mirror;
  logic            r_landed, w_nxt_landed;
  logic            r_airborne;
  logic            r_bvld, w_nxt_bvld;
  logic [1:0]      r_mult, w_nxt_mult;
  logic [1:0]      r_bdist, w_nxt_bdist, w_ldist;
  logic [X_W-1:0]  r_xpos, w_nxt_x, w_x_clamp;
  logic [Y_W-1:0]  r_ypos, w_nxt_y, w_y_clamp;
  logic            w_any, w_launch, w_jump_last, w_fall_last;

  logic signed [XS_W-1:0] w_xstep, w_xsum;
  logic signed [YS_W-1:0] w_ystep, w_ysum;

  assign w_clr       = !rst_n || !bus.module_en;
  assign w_tick      = (r_tick_cnt == TC_W'(TICK_DIV - 1));
  assign w_jump_last = (r_timer == T_W'(JUMP_STEPS - 1));
  assign w_fall_last = (r_timer == T_W'(FALL_STEPS - 1));
  assign w_any       = bus.jump_fail || bus.jump_left || bus.jump_right;

  // strobe decode: fail beats left beats right
  always_comb begin
    w_cmd = CMD_RIGHT;
    if (bus.jump_fail)      w_cmd = CMD_FAIL;
    else if (bus.jump_left) w_cmd = CMD_LEFT;
  end

  // free-running movement tick divider
  always_ff @(posedge clk) begin
    if (w_clr || w_tick) r_tick_cnt <= '0;
    else                 r_tick_cnt <= r_tick_cnt + TC_W'(1);
  end

  // horizontal step with saturation to the screen edges
  always_comb begin
    w_xstep = $signed(XS_W'(STEP_X * int'(r_mult)));
    w_xsum  = r_dir ? ($signed({2'b00, r_xpos}) - w_xstep)
                    : ($signed({2'b00, r_xpos}) + w_xstep);
    if (w_xsum < $signed(XS_W'(X_MIN)))      w_x_clamp = X_W'(X_MIN);
    else if (w_xsum > $signed(XS_W'(X_MAX))) w_x_clamp = X_W'(X_MAX);
    else                                     w_x_clamp = w_xsum[X_W-1:0];
  end

  // vertical step: rise for the first half of a jump, sink for the rest, fall slowly
  always_comb begin
    if (r_state == S_FALL)               w_ystep = $signed(YS_W'(FALL_STEP_Y));
    else if (r_timer < T_W'(HALF))       w_ystep = -$signed(YS_W'(STEP_Y));
    else                                 w_ystep = $signed(YS_W'(STEP_Y));
    w_ysum = $signed({2'b00, r_ypos}) + w_ystep;
    if (w_ysum < $signed(YS_W'(0)))                     w_y_clamp = '0;
    else if (w_ysum > $signed({2'b00, {Y_W{1'b1}}}))    w_y_clamp = '1;
    else                                                w_y_clamp = w_ysum[Y_W-1:0];
  end

  // next-state, trajectory and buffer logic
  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_timer  = r_timer;
    w_nxt_dir    = r_dir;
    w_nxt_mult   = r_mult;
    w_nxt_mirror = r_mirror;
    w_nxt_x      = r_xpos;
    w_nxt_y      = r_ypos;
    w_nxt_landed = 1'b0;
    w_nxt_bvld   = r_bvld;
    w_nxt_bcmd   = r_bcmd;
    w_nxt_bdist  = r_bdist;
    w_launch     = 1'b0;
    w_lcmd       = w_cmd;
    w_ldist      = bus.jump_dist;

    case (r_state)
      S_IDLE: begin
        if (w_any) w_launch = 1'b1;
      end
      S_JUMP: begin
        if (w_tick) begin
          w_nxt_x = w_x_clamp;
          w_nxt_y = w_y_clamp;
          if (w_jump_last) begin
            w_nxt_landed = 1'b1;
            w_nxt_timer  = '0;
            if (r_bvld) begin
              // buffered command wins; any fresh strobe this cycle is dropped
              w_launch   = 1'b1;
              w_lcmd     = r_bcmd;
              w_ldist    = r_bdist;
              w_nxt_bvld = 1'b0;
            end else if (w_any) begin
              w_launch = 1'b1;
            end else begin
              w_nxt_state = S_IDLE;
            end
          end else begin
            w_nxt_timer = r_timer + T_W'(1);
          end
        end
        // mid-flight capture; a stored fail is never displaced by a jump
        if ((BUF_EN != 0) && w_any && !(w_tick && w_jump_last) &&
            (w_cmd == CMD_FAIL || !(r_bvld && r_bcmd == CMD_FAIL))) begin
          w_nxt_bvld  = 1'b1;
          w_nxt_bcmd  = w_cmd;
          w_nxt_bdist = bus.jump_dist;
        end
      end
      S_FALL: begin
        if (w_tick) begin
          w_nxt_y = w_y_clamp;
          if (w_fall_last) begin
            w_nxt_landed = 1'b1;
            w_nxt_timer  = '0;
            w_nxt_state  = S_IDLE;
          end else begin
            w_nxt_timer = r_timer + T_W'(1);
          end
        end
      end
      default: w_nxt_state = S_IDLE;
    endcase

    if (w_launch) begin
      w_nxt_timer = '0;
      if (w_lcmd == CMD_FAIL) begin
        w_nxt_state = S_FALL;
      end else begin
        w_nxt_state  = S_JUMP;
        w_nxt_dir    = (w_lcmd == CMD_LEFT);
        w_nxt_mirror = (w_lcmd == CMD_LEFT);
        w_nxt_mult   = (w_ldist == 2'd0) ? 2'd1 : w_ldist;
      end
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (w_clr) r_state <= S_IDLE;
    else       r_state <= w_nxt_state;
  end

  // datapath and registered outputs
  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_timer    <= '0;
      r_dir      <= 1'b0;
      r_mult     <= 2'd1;
      r_mirror   <= 1'b0;
      r_xpos     <= X_W'(START_X);
      r_ypos     <= Y_W'(START_Y);
      r_landed   <= 1'b0;
      r_airborne <= 1'b0;
      r_bvld     <= 1'b0;
      r_bcmd     <= CMD_RIGHT;
      r_bdist    <= 2'd1;
    end else begin
      r_timer    <= w_nxt_timer;
      r_dir      <= w_nxt_dir;
      r_mult     <= w_nxt_mult;
      r_mirror   <= w_nxt_mirror;
      r_xpos     <= w_nxt_x;
      r_ypos     <= w_nxt_y;
      r_landed   <= w_nxt_landed;
      r_airborne <= (w_nxt_state != S_IDLE);
      r_bvld     <= w_nxt_bvld;
      r_bcmd     <= w_nxt_bcmd;
      r_bdist    <= w_nxt_bdist;
    end
  end

  assign bus.xpos     = r_xpos;
  assign bus.ypos     = r_ypos;
  assign bus.mirror   = r_mirror;
  assign bus.airborne = r_airborne;
  assign bus.landed   = r_landed;
  assign bus.buf_full = r_bvld;

endmodule

// File: tb/tb_char_motion_ctrl.sv
// Directed bench for char_motion_ctrl: two instances (centre start and near left edge)
// driven by the same command stream; expected values worked out by hand.
module tb_char_motion_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic       jl = 1'b0, jr = 1'b0, jf = 1'b0;
  logic [1:0] jd = 2'd1;
  int         e = 0;
  int         n_pass = 0, n_tot = 0;

  char_motion_ctrl_if #(.X_W(10), .Y_W(10)) ifa ();
  char_motion_ctrl_if #(.X_W(10), .Y_W(10)) ifb ();

  assign ifa.module_en = en;  assign ifb.module_en = en;
  assign ifa.jump_left = jl;  assign ifb.jump_left = jl;
  assign ifa.jump_right = jr; assign ifb.jump_right = jr;
  assign ifa.jump_fail = jf;  assign ifb.jump_fail = jf;
  assign ifa.jump_dist = jd;  assign ifb.jump_dist = jd;

  char_motion_ctrl #(.START_X(355), .START_Y(454), .TICK_DIV(4), .JUMP_STEPS(8),
    .STEP_X(1), .STEP_Y(2), .FALL_STEPS(5), .FALL_STEP_Y(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa));

  char_motion_ctrl #(.START_X(5), .START_Y(454), .TICK_DIV(4), .JUMP_STEPS(8),
    .STEP_X(1), .STEP_Y(2), .FALL_STEPS(5), .FALL_STEP_Y(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d (edge %0d)", tag, act, exp, e);
  endtask

  // inputs change and outputs are sampled on the falling edge
  task automatic cyc(input int n);
    repeat (n) begin @(negedge clk); e++; end
  endtask

  task automatic go(input int n);
    while (e < n) cyc(1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b1; jl = 0; jr = 0; jf = 0; jd = 2'd1;
    cyc(3);
    rst_n = 1'b1;
    e = 0;
  endtask

  task automatic pulse(input logic l, input logic r, input logic f, input logic [1:0] d);
    jl = l; jr = r; jf = f; jd = d;
    cyc(1);
    jl = 0; jr = 0; jf = 0;
  endtask

  initial begin
    @(negedge clk);
    // reset state
    do_reset();
    chk("rst_x", ifa.xpos, 355);      chk("rst_y", ifa.ypos, 454);
    chk("rst_mir", ifa.mirror, 0);    chk("rst_air", ifa.airborne, 0);
    chk("rst_lnd", ifa.landed, 0);    chk("rst_buf", ifa.buf_full, 0);
    chk("rstb_x", ifb.xpos, 5);

    // basic right jump, dist 1; ticks land on edges 4,8,..,32
    pulse(0, 1, 0, 2'd1);
    chk("r_air", ifa.airborne, 1);    chk("r_mir", ifa.mirror, 0);
    go(16); chk("r_apex_y", ifa.ypos, 446); chk("r_apex_x", ifa.xpos, 359);
    go(32); chk("r_end_y", ifa.ypos, 454);  chk("r_end_x", ifa.xpos, 363);
    chk("r_lnd", ifa.landed, 1);      chk("r_air_end", ifa.airborne, 0);
    go(33); chk("r_lnd_off", ifa.landed, 0);

    // left jump, dist 3; second instance clamps at the left edge
    do_reset();
    pulse(1, 0, 0, 2'd3);
    chk("l_mir", ifa.mirror, 1);
    go(4);  chk("lb_x_t1", ifb.xpos, 2);
    go(8);  chk("lb_x_t2", ifb.xpos, 0);
    go(16); chk("lb_y_t4", ifb.ypos, 446);
    go(32); chk("l_x", ifa.xpos, 331); chk("l_y", ifa.ypos, 454);
    chk("lb_x", ifb.xpos, 0);          chk("lb_y", ifb.ypos, 454);

    // buffered left overwrites buffered right, chains without an idle cycle
    do_reset();
    pulse(0, 1, 0, 2'd1);
    go(10); pulse(0, 1, 0, 2'd1); chk("b_full1", ifa.buf_full, 1);
    go(20); pulse(1, 0, 0, 2'd2); chk("b_full2", ifa.buf_full, 1);
    go(32); chk("b_lnd", ifa.landed, 1); chk("b_air", ifa.airborne, 1);
    chk("b_empty", ifa.buf_full, 0);     chk("b_mir", ifa.mirror, 1);
    chk("b_x_land", ifa.xpos, 363);
    go(33); chk("b_air2", ifa.airborne, 1); chk("b_lnd_off", ifa.landed, 0);
    go(36); chk("b_x_t1", ifa.xpos, 361); chk("b_y_t1", ifa.ypos, 452);
    go(64); chk("b_x_end", ifa.xpos, 347); chk("b_lnd2", ifa.landed, 1);

    // buffered fail is sticky and becomes a fall after landing
    do_reset();
    pulse(0, 1, 0, 2'd1);
    go(6);  pulse(0, 0, 1, 2'd1);
    go(12); pulse(0, 1, 0, 2'd1); chk("f_full", ifa.buf_full, 1);
    go(32); chk("f_lnd", ifa.landed, 1); chk("f_air", ifa.airborne, 1);
    go(36); chk("f_y_t1", ifa.ypos, 455); chk("f_x_t1", ifa.xpos, 363);
    go(52); chk("f_y_end", ifa.ypos, 459); chk("f_lnd2", ifa.landed, 1);
    chk("f_air_end", ifa.airborne, 0);

    // fail from idle keeps x and mirror; strobes during fall are ignored
    do_reset();
    pulse(1, 0, 0, 2'd1);
    go(32); chk("i_x", ifa.xpos, 347); chk("i_mir", ifa.mirror, 1);
    go(40); pulse(0, 0, 1, 2'd1); chk("i_air", ifa.airborne, 1);
    go(50); pulse(0, 1, 0, 2'd1); chk("i_nobuf", ifa.buf_full, 0);
    go(60); chk("i_y", ifa.ypos, 459); chk("i_lnd", ifa.landed, 1);
    chk("i_x2", ifa.xpos, 347); chk("i_mir2", ifa.mirror, 1);
    go(61); chk("i_lnd_off", ifa.landed, 0); chk("i_air_off", ifa.airborne, 0);
    go(64); chk("i_y_hold", ifa.ypos, 459);

    // reset mid-jump aborts and drops the buffer
    do_reset();
    pulse(0, 1, 0, 2'd1);
    go(5); pulse(1, 0, 0, 2'd1);
    go(11); rst_n = 1'b0; cyc(1);
    chk("ra_x", ifa.xpos, 355); chk("ra_y", ifa.ypos, 454);
    chk("ra_air", ifa.airborne, 0); chk("ra_buf", ifa.buf_full, 0);

    // disable behaves the same
    do_reset();
    pulse(0, 1, 0, 2'd1);
    go(5); pulse(1, 0, 0, 2'd1);
    go(11); en = 1'b0; cyc(1);
    chk("en_x", ifa.xpos, 355); chk("en_y", ifa.ypos, 454);
    chk("en_air", ifa.airborne, 0); chk("en_buf", ifa.buf_full, 0);

    // left and right together: left wins
    do_reset();
    pulse(1, 1, 0, 2'd1);
    chk("lr_mir", ifa.mirror, 1);
    go(4); chk("lr_x", ifa.xpos, 354);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
